// File: rtl/clock_div_checker.sv
// Measures period and high time of a clk_in-synchronous divided clock, flags bad periods and a stuck input.
// Optional high-time (duty) check enabled by defining DUTY_CHECK_EN.
module clock_div_checker #(
    parameter int CNT_W   = 8,
    parameter int EXP_DIV = 5,
    parameter int TOL     = 1,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             err,
    output logic             locked,
    output logic             stuck
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_N);
`ifdef DUTY_CHECK_EN
    localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(EXP_DIV / 2);
    localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'((EXP_DIV + 1) / 2);
`endif

    typedef enum logic {IDLE, MEAS} state_t;

    state_t           state, state_nxt;
    logic             sig_q, sig_d, rise, fall;
    logic [CNT_W-1:0] cnt, hi_cnt;
    logic [GW-1:0]    good_cnt, good_inc;
    logic             in_tol, duty_ok, period_ok;
    logic             do_meas, do_tmo;

    assign rise = sig_q & ~sig_d;
    assign fall = ~sig_q & sig_d;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_q  <= 1'b0;
            sig_d  <= 1'b0;
            cnt    <= '0;
            hi_cnt <= '0;
        end else begin
            sig_q <= sig_in;
            sig_d <= sig_q;
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (fall)
                hi_cnt <= cnt;
        end
    end

    // Unsigned distance from the expected period, ordered so it never wraps.
    assign in_tol = (cnt >= EXP_C) ? ((cnt - EXP_C) <= TOL_C) : ((EXP_C - cnt) <= TOL_C);

`ifdef DUTY_CHECK_EN
    assign duty_ok = (hi_cnt >= DUTY_LO) && (hi_cnt <= DUTY_HI);
`else
    assign duty_ok = 1'b1;
`endif

    assign period_ok = in_tol & duty_ok;
    assign good_inc  = (good_cnt == LOCK_C) ? good_cnt : good_cnt + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = MEAS;
            MEAS: if (!rise && cnt == TMO_C) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A rise in the timeout cycle takes priority and is measured normally.
    always_comb begin
        do_meas = (state == MEAS) && rise;
        do_tmo  = (state == MEAS) && !rise && (cnt == TMO_C);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
            good_cnt   <= '0;
        end else begin
            meas_valid <= do_meas;
            err        <= do_meas & ~period_ok;
            if (do_meas) begin
                period    <= cnt;
                high_time <= hi_cnt;
                if (period_ok) begin
                    good_cnt <= good_inc;
                    locked   <= (good_inc == LOCK_C);
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
            if (do_tmo) begin
                stuck    <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
            end
            if (rise)
                stuck <= 1'b0;
        end
    end

endmodule
